watch_mode_ctrl: RTL
====================

Name: watch_mode_ctrl

Overview:
Central sequencer for the watch top level. It owns the one-hot mode ring across the seven function modules (date, clock, alarm, stopwatch, timer, d_day, ladder) and gates mode rotation on the active module's norm flag. It selects the active module's 48-bit display word and arbitrates alarm requests from all modules onto the single alarm output, with a timed ring and button dismissal.

Parameters:
NUM_MODES, 7, number of function modules in the mode ring
RESET_MODE, 5, index of the one-hot bit set after reset (d_day)
DISP_W, 48, display word width per module
RING_CYCLES, 1000, clk cycles an alarm rings before auto-dismiss (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
up  in  1  up button, active-high level, already synchronised
down  in  1  down button, active-high level, already synchronised
esc  in  1  escape button, active-high level, already synchronised
norm  in  NUM_MODES  per-module "in normal view" flag; rotation is allowed only from a normal view
disp_bus  in  NUM_MODES*DISP_W  concatenated module display words; module i occupies bits [i*DISP_W +: DISP_W]
alarm_req  in  NUM_MODES  per-module alarm request level
mode  out  NUM_MODES  one-hot active mode, drives each module's mode input
out  out  DISP_W  registered display word of the active module
o_m  out  8  mode indicator, {1'b0, mode}
alarm  out  1  buzzer drive
alarm_src  out  3  index of the module currently or last ringing

Behaviour:
- Reset values: mode = 1<<RESET_MODE; out = 0; o_m = {1'b0, 1<<RESET_MODE}; alarm = 0; alarm_src = 0; pending = 0.
- Reset state of the previous-level registers: up/down/esc/alarm_req previous-level registers reset to all-ones, so a level already held through reset produces no edge.
- Edges: edge = level & ~prev, evaluated every cycle.
- Rotation rule: rotation requires (mode & norm) != 0 and arbiter in IDLE.
  - up edge: rotate left, mode[i] moves to mode[i+1] and mode[6] moves to mode[0].
  - down edge: rotate right.
  - up and down edges in the same cycle: no change.
- Blocked edges: an edge arriving while blocked is discarded, not queued.
- mode registered: new value is visible 1 cycle after the edge.
- out: registered 1 cycle after mode, out <= disp_bus slice selected by the current mode. On a mode change, out shows the new module 2 cycles after the button edge. If mode is ever not one-hot, out <= 0 and mode is forced back to 1<<RESET_MODE.
- o_m: tracks mode with the same 1-cycle latency as out.
- Alarm arbiter, two states:
  - pending[i] is set on an alarm_req[i] rising edge in any state, and cleared when request i is granted.
  - IDLE: if pending != 0, grant the lowest set index, then alarm_src <= index, cnt <= RING_CYCLES-1, go to RING. alarm = 0.
  - RING: alarm = 1. cnt decrements each cycle. Go to IDLE when cnt == 0 or on any edge of esc/up/down. A dismissing button edge is consumed and causes no rotation.
- Simultaneous events:
  - A request edge on the dismissal cycle is pended.
  - The arbiter then spends exactly one IDLE cycle with alarm = 0 before ringing the next request.
  - A request edge for the index already ringing is pended and rings again after the current ring ends.
- Registered outputs: alarm and alarm_src are registered (Moore). alarm rises 1 cycle after the IDLE grant cycle.
- cnt width: $clog2(RING_CYCLES).
- rst mid-ring: alarm = 0 and pending cleared on the next edge; mode returns to RESET_MODE.

Decomposition:
- Package watch_pkg:
  - NUM_MODES and DISP_W
  - mode index constants MODE_DATE=0, MODE_CLOCK=1, MODE_ALARM=2, MODE_STOPWATCH=3, MODE_TIMER=4, MODE_DDAY=5, MODE_LADDER=6
  - arbiter state enum {ARB_IDLE, ARB_RING}
- Sub-module watch_alarm_arb: pending register, priority grant, ring counter and dismissal. Inputs are button edges and alarm_req; outputs are alarm, alarm_src and a busy flag. The top keeps the edge detect, mode ring and display mux.

Test Plan:
- Reset: hold rst 2 cycles with up=1 held. Require mode=7'b0100000, out=0, alarm=0, and no rotation after release while up stays high.
- Rotation wrap: norm=7'h7F, three up pulses. Require mode=0100000 -> 1000000 -> 0000001 -> 0000010. out equals disp_bus[95:48] 2 cycles after the third edge. A down pulse returns mode to 0000001.
- Norm gating: norm=7'h00. An up pulse leaves mode unchanged. Raise norm[5] only; the up pulse must not have been queued. A fresh up pulse gives mode=1000000. Simultaneous up+down pulses give no change.
- Auto-dismiss, RING_CYCLES=8: alarm_req[4] 0->1. Require alarm=1 for exactly 8 cycles and alarm_src=4. Keeping alarm_req[4] high does not retrigger.
- Priority and pending: alarm_req[4] and alarm_req[2] rise in the same cycle. Require alarm_src=2 first. An esc pulse dismisses it; alarm is low 1 cycle, then alarm_src=4 rings. An up edge during the ring dismisses and mode is unchanged.
- Reset mid-ring: assert rst while alarm=1 with pending[4] set. Require alarm=0 and no later ring for 4 after release.

Source files
------------

// File: rtl/watch_pkg.sv
// Shared constants and types for the watch top-level sequencer.
// Mode indices follow the bit positions of the one-hot mode ring.
package watch_pkg;

  localparam int unsigned NUM_MODES = 7;
  localparam int unsigned DISP_W    = 48;
  localparam int unsigned SRC_W     = 3;

  localparam int unsigned MODE_DATE      = 0;
  localparam int unsigned MODE_CLOCK     = 1;
  localparam int unsigned MODE_ALARM     = 2;
  localparam int unsigned MODE_STOPWATCH = 3;
  localparam int unsigned MODE_TIMER     = 4;
  localparam int unsigned MODE_DDAY      = 5;
  localparam int unsigned MODE_LADDER    = 6;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_RING = 1'b1
  } arb_state_e;

  // True when exactly one bit of the mode vector is set.
  function automatic logic is_onehot(input logic [NUM_MODES-1:0] v);
    return (v != '0) && ((v & (v - NUM_MODES'(1))) == '0);
  endfunction

endpackage

// File: rtl/watch_alarm_arb.sv
// Alarm arbiter: latches request edges, grants the lowest pending index,
// rings for a fixed number of cycles or until any button edge dismisses it.
module watch_alarm_arb
  import watch_pkg::*;
#(
  parameter int unsigned RING_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_edge_i,
  input  logic [NUM_MODES-1:0] req_edge_i,
  output logic                 alarm_o,
  output logic [SRC_W-1:0]     alarm_src_o,
  output logic                 busy_o
);

  localparam int unsigned CNT_W = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;

  arb_state_e           state_q, state_d;
  logic [NUM_MODES-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SRC_W-1:0]     src_q, src_d;
  logic                 alarm_q, alarm_d;
  logic                 found;
  logic [SRC_W-1:0]     gidx;

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ARB_IDLE;
      pending_q <= '0;
      cnt_q     <= '0;
      src_q     <= '0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      src_q     <= src_d;
      alarm_q   <= alarm_d;
    end
  end

  // Lowest set pending index wins
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    for (int i = NUM_MODES - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        found = 1'b1;
        gidx  = SRC_W'(i);
      end
    end
  end

  // Next state; new request edges are OR'd in after any grant clear
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    case (state_q)
      ARB_IDLE: begin
        if (found) begin
          pending_d = pending_q & ~(NUM_MODES'(1) << gidx);
          src_d     = gidx;
          cnt_d     = CNT_W'(RING_CYCLES - 1);
          state_d   = ARB_RING;
        end
      end
      ARB_RING: begin
        cnt_d = cnt_q - CNT_W'(1);
        if ((cnt_q == '0) || btn_edge_i) begin
          state_d = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
    pending_d = pending_d | req_edge_i;
  end

  // Moore output decode
  always_comb begin
    alarm_d = (state_d == ARB_RING);
  end

  assign alarm_o     = alarm_q;
  assign alarm_src_o = src_q;
  assign busy_o      = (state_q == ARB_RING);

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch sequencer: button edge detect, one-hot mode ring gated on the active
// module's normal view, registered display mux and alarm arbitration.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int unsigned RESET_MODE  = MODE_DDAY,
  parameter int unsigned RING_CYCLES = 1000
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        up,
  input  logic                        down,
  input  logic                        esc,
  input  logic [NUM_MODES-1:0]        norm,
  input  logic [NUM_MODES*DISP_W-1:0] disp_bus,
  input  logic [NUM_MODES-1:0]        alarm_req,
  output logic [NUM_MODES-1:0]        mode,
  output logic [DISP_W-1:0]           out,
  output logic [7:0]                  o_m,
  output logic                        alarm,
  output logic [SRC_W-1:0]            alarm_src
);

  localparam logic [NUM_MODES-1:0] MODE_RST = NUM_MODES'(1) << RESET_MODE;

  logic                 up_q, down_q, esc_q;
  logic [NUM_MODES-1:0] req_q;
  logic                 up_e, down_e, esc_e;
  logic [NUM_MODES-1:0] req_e;
  logic [NUM_MODES-1:0] mode_q, mode_d;
  logic [DISP_W-1:0]    out_q, out_d;
  logic [7:0]           o_m_q;
  logic [DISP_W-1:0]    disp_sel;
  logic                 arb_busy;
  logic                 rot_ok;

  // Previous levels reset high so a level held through reset is not an edge
  always_ff @(posedge clk) begin
    if (rst) begin
      up_q   <= 1'b1;
      down_q <= 1'b1;
      esc_q  <= 1'b1;
      req_q  <= '1;
    end else begin
      up_q   <= up;
      down_q <= down;
      esc_q  <= esc;
      req_q  <= alarm_req;
    end
  end

  assign up_e   = up & ~up_q;
  assign down_e = down & ~down_q;
  assign esc_e  = esc & ~esc_q;
  assign req_e  = alarm_req & ~req_q;

  // Rotation only from a normal view and with no alarm ringing
  assign rot_ok = ((mode_q & norm) != '0) && !arb_busy;

  always_comb begin
    mode_d = mode_q;
    if (!is_onehot(mode_q)) begin
      mode_d = MODE_RST;
    end else if (rot_ok && up_e && !down_e) begin
      mode_d = {mode_q[NUM_MODES-2:0], mode_q[NUM_MODES-1]};
    end else if (rot_ok && down_e && !up_e) begin
      mode_d = {mode_q[0], mode_q[NUM_MODES-1:1]};
    end
  end

  always_comb begin
    disp_sel = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (mode_q[i]) begin
        disp_sel = disp_sel | disp_bus[i*DISP_W +: DISP_W];
      end
    end
    out_d = is_onehot(mode_q) ? disp_sel : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= MODE_RST;
      out_q  <= '0;
      o_m_q  <= 8'(MODE_RST);
    end else begin
      mode_q <= mode_d;
      out_q  <= out_d;
      o_m_q  <= 8'(mode_q);
    end
  end

  watch_alarm_arb #(
    .RING_CYCLES (RING_CYCLES)
  ) u_arb (
    .clk         (clk),
    .rst         (rst),
    .btn_edge_i  (up_e | down_e | esc_e),
    .req_edge_i  (req_e),
    .alarm_o     (alarm),
    .alarm_src_o (alarm_src),
    .busy_o      (arb_busy)
  );

  assign mode = mode_q;
  assign out  = out_q;
  assign o_m  = o_m_q;

endmodule
